muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit, directly downstream of the register file's read ports (rd1/rd2) and upstream of its write port (wd3/wa3/we3). It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While an operation is in flight it holds the single-cycle core with a stall signal. On completion it produces a one-cycle register-file write.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and data bundle between the core's decode/register-file path
// and the iterative multiply/divide unit.
interface muldiv_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd_addr;
   logic [31:0] result;
   logic [4:0]  wa;
   logic        we;
   logic        done;
   logic        busy;
   logic        stall;

   modport master (
      output start, funct3, a, b, rd_addr,
      input  result, wa, we, done, busy, stall
   );

   modport slave (
      input  start, funct3, a, b, rd_addr,
      output result, wa, we, done, busy, stall
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One shift-add (multiply) or
// restoring-subtract (divide) step per cycle over 32 cycles, with
// single-cycle fast paths for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start; operands sampled on the accept edge
// RUN   | 32 iterations on magnitudes, sign fix-up on the last one
// DONE  | one-cycle register-file write (we/done high, stall low)
module muldiv_unit (
   input  logic      clk,
   input  logic      rst,
   muldiv_if.slave   bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [2:0]  op;
   logic        sign_a;
   logic        sign_b;
   logic [31:0] opnd;
   logic [63:0] acc;
   logic [31:0] result_q;
   logic [4:0]  wa_q;

   logic        is_div;
   logic        a_signed;
   logic        b_signed;
   logic        in_sa;
   logic        in_sb;
   logic [31:0] in_ma;
   logic [31:0] in_mb;
   logic        div_zero;
   logic        div_ovf;
   logic [31:0] fast_res;

   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] div_next;
   logic [63:0] iter_next;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] final_res;

   // Operand decode at the accept edge: signedness, magnitudes, fast paths.
   always_comb begin
      is_div   = bus.funct3[2];
      a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                 (bus.funct3 == 3'b110);
      in_sa    = a_signed & bus.a[31];
      in_sb    = b_signed & bus.b[31];
      in_ma    = in_sa ? (~bus.a + 32'd1) : bus.a;
      in_mb    = in_sb ? (~bus.b + 32'd1) : bus.b;
      div_zero = is_div && (bus.b == 32'd0);
      div_ovf  = is_div && !bus.funct3[0] &&
                 (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
      fast_res = 32'd0;
      if (div_zero)
         fast_res = bus.funct3[1] ? bus.a : 32'hFFFF_FFFF;
      else
         fast_res = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
   end

   // One iteration step; multiply keeps {partial, multiplier} in acc, divide
   // keeps {remainder, dividend/quotient} in acc, opnd holds the other operand.
   always_comb begin
      mul_sum   = acc[0] ? ({1'b0, acc[63:32]} + {1'b0, opnd}) : {1'b0, acc[63:32]};
      mul_next  = {mul_sum, acc[31:1]};
      div_shift = {acc[63:32], acc[31]};
      div_diff  = div_shift - {1'b0, opnd};
      div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                               : {div_diff[31:0], acc[30:0], 1'b1};
      iter_next = op[2] ? div_next : mul_next;
   end

   // Sign fix-up and result selection applied to the final iteration.
   always_comb begin
      prod_fix  = (sign_a ^ sign_b) ? (~iter_next + 64'd1) : iter_next;
      quo_fix   = (sign_a ^ sign_b) ? (~iter_next[31:0] + 32'd1) : iter_next[31:0];
      rem_fix   = sign_a ? (~iter_next[63:32] + 32'd1) : iter_next[63:32];
      final_res = prod_fix[63:32];
      if (op[2])
         final_res = op[1] ? rem_fix : quo_fix;
      else if (op[1:0] == 2'b00)
         final_res = prod_fix[31:0];
   end

   // Sequencer: accept, iterate, write back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 5'd0;
         op       <= 3'd0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         opnd     <= 32'd0;
         acc      <= 64'd0;
         result_q <= 32'd0;
         wa_q     <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op     <= bus.funct3;
                  wa_q   <= bus.rd_addr;
                  sign_a <= in_sa;
                  sign_b <= in_sb;
                  cnt    <= 5'd0;
                  if (is_div) begin
                     opnd <= in_mb;
                     acc  <= {32'd0, in_ma};
                  end else begin
                     opnd <= in_ma;
                     acc  <= {32'd0, in_mb};
                  end
                  if (div_zero || div_ovf) begin
                     result_q <= fast_res;
                     state    <= DONE;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc <= iter_next;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  result_q <= final_res;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.wa     = wa_q;
   assign bus.we     = (state == DONE);
   assign bus.done   = (state == DONE);
   assign bus.busy   = (state != IDLE);
   assign bus.stall  = (bus.start && (state == IDLE)) || (state == RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, reset mid-run,
// held-start behaviour and randomized operations against an arithmetic model.
module tb_muldiv_unit;

   logic clk;
   logic rst;
   int   vectors;
   int   errs;

   muldiv_if bus ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub, p;
      int ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = a;
      ib = b;
      case (f3)
         3'b000: begin p = sa * sb; return p[31:0];  end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
      if (f3[2] && (b == 0)) return 1;
      if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.funct3  = f3;
      bus.a       = a;
      bus.b       = b;
      bus.rd_addr = rd;
   endtask

   // Called during the start cycle; operands are scrambled once accepted.
   task automatic wait_done(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input bit hold, input string tag);
      int n, lat, stall_cnt;
      bit got;
      logic [31:0] exp;
      exp = ref_res(f3, a, b);
      lat = ref_lat(f3, a, b);
      #1;
      stall_cnt = bus.stall ? 1 : 0;
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done) got = 1'b1;
         else begin
            if (bus.stall) stall_cnt++;
            bus.a = $urandom;
            bus.b = $urandom;
         end
      end
      check({tag, " latency"}, 32'(n), 32'(lat));
      check({tag, " result"}, bus.result, exp);
      check({tag, " wa"}, {27'd0, bus.wa}, {27'd0, rd});
      check({tag, " we"}, {31'd0, bus.we}, 32'd1);
      check({tag, " stall_in_done"}, {31'd0, bus.stall}, 32'd0);
      check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(lat));
      if (!hold) bus.start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " idle_after"}, {30'd0, bus.busy, bus.we}, 32'd0);
      if (hold) begin
         bus.start = 1'b0;
         @(posedge clk);
         #1;
         check({tag, " no_restart"}, {30'd0, bus.busy, bus.done}, 32'd0);
      end
   endtask

   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
      launch(f3, a, b, rd);
      wait_done(f3, a, b, rd, 1'b0, tag);
   endtask

   initial begin
      vectors     = 0;
      errs        = 0;
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.funct3  = 3'd0;
      bus.a       = 32'd0;
      bus.b       = 32'd0;
      bus.rd_addr = 5'd0;
      #1;
      check("reset result", bus.result, 32'd0);
      check("reset ctl", {27'd0, bus.wa}, 32'd0);
      check("reset flags", {28'd0, bus.we, bus.done, bus.busy, bus.stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(3'b000, 32'd7, 32'd6, 5'd5, "mul");
      do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh");
      do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhsu");
      do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhu");
      do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, "div");
      do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem");
      do_op(3'b101, 32'd100, 32'd7, 5'd7, "divu");
      do_op(3'b111, 32'd100, 32'd7, 5'd8, "remu");
      do_op(3'b101, 32'h1234, 32'd0, 5'd9, "divu_z");
      do_op(3'b110, 32'h1234, 32'd0, 5'd10, "rem_z");
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf");
      do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "rem_ovf");
      do_op(3'b000, 32'd9, 32'd9, 5'd0, "mul_x0");

      launch(3'b000, 32'd7, 32'd6, 5'd5);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid result", bus.result, 32'd0);
      check("rst_mid wa", {27'd0, bus.wa}, 32'd0);
      check("rst_mid flags", {28'd0, bus.we, bus.done, bus.busy, bus.stall}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("rst_mid no_done", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.a = 32'd7;
      bus.b = 32'd6;
      wait_done(3'b000, 32'd7, 32'd6, 5'd5, 1'b0, "rst_restart");

      launch(3'b101, 32'hDEAD_BEEF, 32'd13, 5'd17);
      wait_done(3'b101, 32'hDEAD_BEEF, 32'd13, 5'd17, 1'b1, "hold");

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f3;
         logic [31:0] ra, rb;
         logic [4:0]  rd;
         f3 = 3'($urandom_range(0, 7));
         ra = pick_val();
         rb = pick_val();
         rd = 5'($urandom);
         do_op(f3, ra, rb, rd, $sformatf("rnd%0d_f%0d", i, f3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
